// File: rtl/driver_config_loader.sv
// Loads the SPI configuration word into a daisy chain of LED drivers using the
// FC write protocol (FCWRTEN latch sequence, then MSB-first data with trailing LAT).
module driver_config_loader #(
  parameter int CONFIG_W    = 48,
  parameter int NB_DRIVERS  = 1,
  parameter int FCWRTEN_LAT = 15,
  parameter int WRTFC_LAT   = 5
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [CONFIG_W-1:0] config_in,
  input  logic                new_config_available,
  input  logic                cfg_grant,
  output logic                cfg_req,
  output logic                driver_sclk,
  output logic                driver_sin,
  output logic                driver_lat,
  output logic                busy,
  output logic                config_done
);

  localparam int SHIFT_PULSES = NB_DRIVERS * CONFIG_W;
  localparam int CNT_MAX      = (FCWRTEN_LAT > SHIFT_PULSES) ? FCWRTEN_LAT : SHIFT_PULSES;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam int IDX_W        = (CONFIG_W > 1) ? $clog2(CONFIG_W) : 1;

  localparam logic [CNT_W-1:0] FC_LAST   = CNT_W'(FCWRTEN_LAT - 1);
  localparam logic [CNT_W-1:0] SH_LAST   = CNT_W'(SHIFT_PULSES - 1);
  localparam logic [CNT_W-1:0] LAT_FIRST = CNT_W'(SHIFT_PULSES - WRTFC_LAT);
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(CONFIG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_FCWRTEN,
    S_GAP,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic                phase, phase_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    bit_idx, idx_n;
  logic                pending, pending_n;
  logic                capture;
  logic [CONFIG_W-1:0] shadow_cfg;

  logic sync_p0, sync_p1, edge_p2;
  logic trigger;

  logic req_n, sclk_n, sin_n, lat_n, busy_n, done_n;

  // Stage p0/p1: metastability filter for the sck-domain flag; p2: edge history
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      edge_p2 <= 1'b0;
    end else begin
      sync_p0 <= new_config_available;
      sync_p1 <= sync_p0;
      edge_p2 <= sync_p1;
    end
  end

  assign trigger = sync_p1 & ~edge_p2;

  // Shadow word is data only; it is always rewritten before it is shifted out
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow_cfg <= config_in;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = cnt;
    idx_n     = bit_idx;
    pending_n = pending | (trigger & (state != S_IDLE));
    capture   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (trigger) begin
          state_n = S_REQUEST;
          capture = 1'b1;
        end
      end
      S_REQUEST: begin
        if (cfg_grant) begin
          state_n = S_FCWRTEN;
          phase_n = 1'b0;
          cnt_n   = '0;
        end
      end
      S_FCWRTEN: begin
        phase_n = ~phase;
        if (phase) begin
          if (cnt == FC_LAST) begin
            state_n = S_GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        phase_n = ~phase;
        if (phase) begin
          state_n = S_SHIFT;
          cnt_n   = '0;
          idx_n   = IDX_TOP;
        end
      end
      S_SHIFT: begin
        phase_n = ~phase;
        if (phase) begin
          if (cnt == SH_LAST) begin
            state_n = S_DONE;
          end else begin
            cnt_n = cnt + 1'b1;
            // every driver in the chain receives the same word, so wrap per word
            idx_n = (bit_idx == '0) ? IDX_TOP : bit_idx - 1'b1;
          end
        end
      end
      S_DONE: begin
        phase_n = 1'b0;
        cnt_n   = '0;
        if (pending_n) begin
          state_n   = S_REQUEST;
          pending_n = 1'b0;
          capture   = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave a register glitch-free
    req_n  = (state_n == S_REQUEST) || (state_n == S_FCWRTEN) ||
             (state_n == S_GAP)     || (state_n == S_SHIFT);
    sclk_n = phase_n && ((state_n == S_FCWRTEN) || (state_n == S_SHIFT));
    lat_n  = (state_n == S_FCWRTEN) || ((state_n == S_SHIFT) && (cnt_n >= LAT_FIRST));
    sin_n  = (state_n == S_SHIFT) ? shadow_cfg[idx_n] : 1'b0;
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      pending     <= 1'b0;
      cfg_req     <= 1'b0;
      driver_sclk <= 1'b0;
      driver_sin  <= 1'b0;
      driver_lat  <= 1'b0;
      busy        <= 1'b0;
      config_done <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      cnt         <= cnt_n;
      bit_idx     <= idx_n;
      pending     <= pending_n;
      cfg_req     <= req_n;
      driver_sclk <= sclk_n;
      driver_sin  <= sin_n;
      driver_lat  <= lat_n;
      busy        <= busy_n;
      config_done <= done_n;
    end
  end

endmodule

// File: tb/tb_driver_config_loader.sv
// Bench for driver_config_loader: single-driver and three-driver instances,
// serial stream compared against a per-pulse model built from the protocol rules.
module tb_driver_config_loader;

  localparam int CW  = 48;
  localparam int FCL = 15;
  localparam int WL  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst, flag1, flag3, grant;
  logic [CW-1:0] cfg;
  logic req1, sclk1, sin1, lat1, busy1, done1;
  logic req3, sclk3, sin3, lat3, busy3, done3;
  logic sel3;
  logic o_req, o_sclk, o_sin, o_lat, o_busy, o_done;

  driver_config_loader #(.CONFIG_W(CW), .NB_DRIVERS(1), .FCWRTEN_LAT(FCL), .WRTFC_LAT(WL)) dut1 (
    .clk(clk), .nrst(nrst), .config_in(cfg), .new_config_available(flag1), .cfg_grant(grant),
    .cfg_req(req1), .driver_sclk(sclk1), .driver_sin(sin1), .driver_lat(lat1),
    .busy(busy1), .config_done(done1)
  );

  driver_config_loader #(.CONFIG_W(CW), .NB_DRIVERS(3), .FCWRTEN_LAT(FCL), .WRTFC_LAT(WL)) dut3 (
    .clk(clk), .nrst(nrst), .config_in(cfg), .new_config_available(flag3), .cfg_grant(grant),
    .cfg_req(req3), .driver_sclk(sclk3), .driver_sin(sin3), .driver_lat(lat3),
    .busy(busy3), .config_done(done3)
  );

  assign o_req  = sel3 ? req3  : req1;
  assign o_sclk = sel3 ? sclk3 : sclk1;
  assign o_sin  = sel3 ? sin3  : sin1;
  assign o_lat  = sel3 ? lat3  : lat1;
  assign o_busy = sel3 ? busy3 : busy1;
  assign o_done = sel3 ? done3 : done1;

  int total = 0;
  int bad   = 0;

  bit sin_q[$];
  bit lat_q[$];
  int low_q[$];
  bit exp_sin[$];
  bit exp_lat[$];
  int grant_to_done, req_wait, early_sclk, unstable;
  logic [3:0] done_snap;
  int act_done, act_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [CW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CW-1:0];
  endfunction

  // Expected pulse sequence: write-enable command, then the word per driver MSB first,
  // LAT only on the last WL bits of the final word.
  function automatic void build_expect(input logic [CW-1:0] w, input int nb);
    exp_sin.delete();
    exp_lat.delete();
    for (int i = 0; i < FCL; i++) begin
      exp_sin.push_back(1'b0);
      exp_lat.push_back(1'b1);
    end
    for (int d = 0; d < nb; d++) begin
      for (int b = CW - 1; b >= 0; b--) begin
        exp_sin.push_back(w[b]);
        exp_lat.push_back((d == nb - 1) && (b < WL));
      end
    end
  endfunction

  // Samples on the falling edge until config_done (or the cycle budget runs out).
  task automatic collect(input int limit);
    logic prev_sclk, prev_sin, prev_lat;
    int   low_run, gstart;
    bit   seen;
    sin_q.delete();
    lat_q.delete();
    low_q.delete();
    grant_to_done = -1;
    req_wait      = 0;
    early_sclk    = 0;
    unstable      = 0;
    done_snap     = 4'hf;
    prev_sclk = o_sclk;
    prev_sin  = o_sin;
    prev_lat  = o_lat;
    low_run   = 0;
    gstart    = -1;
    seen      = 1'b0;
    for (int cyc = 0; cyc < limit && !seen; cyc++) begin
      @(negedge clk);
      if (gstart < 0) begin
        if (o_sclk) early_sclk++;
        if (o_req && grant) gstart = cyc;
        else if (o_req) req_wait++;
      end
      if (o_sclk && !prev_sclk) begin
        sin_q.push_back(o_sin);
        lat_q.push_back(o_lat);
        low_q.push_back(low_run);
        if (o_sin !== prev_sin || o_lat !== prev_lat) unstable++;
        low_run = 0;
      end else if (!o_sclk) begin
        low_run++;
      end
      if (o_done) begin
        seen = 1'b1;
        if (gstart >= 0) grant_to_done = cyc - gstart;
        done_snap = {o_sclk, o_lat, o_req, o_busy};
      end
      prev_sclk = o_sclk;
      prev_sin  = o_sin;
      prev_lat  = o_lat;
    end
  endtask

  task automatic verify_load(input string tag, input logic [CW-1:0] w, input int nb);
    int n, bad_low;
    build_expect(w, nb);
    check({tag, "_pulses"}, 64'(sin_q.size()), 64'(exp_sin.size()));
    n = (sin_q.size() < exp_sin.size()) ? sin_q.size() : exp_sin.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pulse%0d_sin_lat", tag, i + 1),
            64'({sin_q[i], lat_q[i]}), 64'({exp_sin[i], exp_lat[i]}));
    bad_low = 0;
    for (int i = 1; i < low_q.size(); i++)
      if (low_q[i] != ((i == FCL) ? 3 : 1)) bad_low++;
    check({tag, "_gap_shape"}, 64'(bad_low), 64'd0);
    check({tag, "_setup_stable"}, 64'(unstable), 64'd0);
    check({tag, "_duration"}, 64'(grant_to_done), 64'(2 * (FCL + 1 + nb * CW) + 1));
    check({tag, "_done_outputs"}, 64'(done_snap), 64'(4'b0001));
  endtask

  task automatic count_activity(input int n);
    act_done = 0;
    act_busy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_done) act_done++;
      if (o_busy) act_busy++;
    end
  endtask

  initial begin
    logic [CW-1:0] w;
    logic [CW-1:0] obs_word;
    int d;

    nrst = 1'b0; flag1 = 1'b0; flag3 = 1'b0; grant = 1'b0; sel3 = 1'b0; cfg = '0;
    step(3);
    check("rst_dut1_outputs", 64'({req1, sclk1, sin1, lat1, busy1, done1}), 64'd0);
    check("rst_dut3_outputs", 64'({req3, sclk3, sin3, lat3, busy3, done3}), 64'd0);
    nrst = 1'b1;
    step(2);

    // Basic load with grant already present
    cfg = 48'hA5A5_0F0F_C3C3; grant = 1'b1;
    flag1 = 1'b1;
    @(posedge clk); #1; check("t1_req_edge1", 64'(o_req), 64'd0);
    @(posedge clk); #1; check("t1_req_edge2", 64'(o_req), 64'd0);
    @(posedge clk); #1; check("t1_req_edge3", 64'(o_req), 64'd1);
    collect(300);
    verify_load("t1", 48'hA5A5_0F0F_C3C3, 1);
    obs_word = '0;
    for (int i = 0; i < CW && (FCL + i) < sin_q.size(); i++) obs_word = {obs_word[CW-2:0], sin_q[FCL + i]};
    check("t1_word", 64'(obs_word), 64'(48'hA5A5_0F0F_C3C3));
    @(negedge clk);
    check("t1_done_one_cycle", 64'({o_done, o_busy}), 64'd0);

    // Grant withheld 40 cycles, dropped mid-shift
    step(1);
    grant = 1'b0; flag1 = 1'b0;
    step(4);
    w = rand_word(); cfg = w; flag1 = 1'b1;
    fork
      collect(400);
      begin
        step(43); grant = 1'b1;
        step(60); grant = 1'b0;
      end
    join
    verify_load("t2", w, 1);
    check("t2_req_wait", 64'(req_wait), 64'd40);
    check("t2_early_sclk", 64'(early_sclk), 64'd0);

    // Randomised words and grant delays
    for (int k = 0; k < 4; k++) begin
      step(1);
      grant = 1'b0; flag1 = 1'b0;
      step(4);
      w = rand_word(); cfg = w; flag1 = 1'b1;
      d = int'($urandom_range(20, 0));
      fork
        collect(400);
        begin step(3 + d); grant = 1'b1; end
      join
      verify_load($sformatf("rnd%0d", k), w, 1);
      check($sformatf("rnd%0d_req_wait", k), 64'(req_wait), 64'(d));
    end

    // Three-driver chain
    step(1);
    sel3 = 1'b1; grant = 1'b1; cfg = 48'h0000_0000_0001;
    step(4);
    flag3 = 1'b1;
    collect(800);
    verify_load("t3", 48'h0000_0000_0001, 3);
    step(1);
    sel3 = 1'b0;

    // Retriggers during a load collapse into one pending load with the new word
    flag1 = 1'b0;
    w = rand_word(); cfg = w;
    step(4);
    flag1 = 1'b1;
    fork
      collect(400);
      begin
        step(50); flag1 = 1'b0;
        step(3);  cfg = 48'h1234_5678_9ABC; flag1 = 1'b1;
        step(3);  flag1 = 1'b0;
        step(3);  flag1 = 1'b1;
      end
    join
    verify_load("t4a", w, 1);
    collect(400);
    verify_load("t4b", 48'h1234_5678_9ABC, 1);
    count_activity(400);
    check("t4_no_third_done", 64'(act_done), 64'd0);
    check("t4_no_third_busy", 64'(act_busy), 64'd0);

    // Reset in the middle of the shift phase
    step(1);
    flag1 = 1'b0;
    step(4);
    cfg = rand_word(); flag1 = 1'b1;
    step(10); flag1 = 1'b0;
    step(50);
    check("t5_busy_before_rst", 64'(o_busy), 64'd1);
    nrst = 1'b0;
    #1;
    check("t5_outputs_in_rst", 64'({o_req, o_sclk, o_sin, o_lat, o_busy, o_done}), 64'd0);
    step(3);
    nrst = 1'b1;
    count_activity(100);
    check("t5_idle_after_rst", 64'(act_busy + act_done), 64'd0);
    step(1);
    w = rand_word(); cfg = w; flag1 = 1'b1;
    collect(400);
    verify_load("t5", w, 1);

    // Flag held high long after a load
    step(1);
    flag1 = 1'b0;
    step(4);
    cfg = rand_word(); flag1 = 1'b1;
    count_activity(1200);
    check("t6_single_done", 64'(act_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
